// File: rtl/cpu_clock_ctrl.sv
// Debounced run/step controller for the CPU tick enable; press-to-tick latency DEB_CYCLES+3, no backpressure.
// Optional break exit from RUN is built only when CLKCTRL_BREAK_EN is defined.

module cpu_clock_ctrl_btn #(
  parameter int DEB_CYCLES = 500000
) (
  input  logic clkin,
  input  logic reset_n,
  input  logic key_n,
  output logic press
);
  localparam int CW = (DEB_CYCLES > 2) ? $clog2(DEB_CYCLES) : 1;

  logic          sync1, sync2, deb, deb_d, armed;
  logic [1:0]    fill;
  logic [CW-1:0] cnt;

  always_ff @(posedge clkin or negedge reset_n) begin
    if (!reset_n) begin
      sync1 <= 1'b1;
      sync2 <= 1'b1;
      deb   <= 1'b1;
      deb_d <= 1'b1;
      armed <= 1'b0;
      fill  <= 2'b00;
      cnt   <= '0;
      press <= 1'b0;
    end else begin
      sync1 <= key_n;
      sync2 <= sync1;
      fill  <= {fill[0], 1'b1};
      deb_d <= deb;
      // A key held through reset must be seen released (past the reset-valued sync flops) before it can press.
      if (fill[1] && sync2)
        armed <= 1'b1;
      if (sync2 == deb) begin
        cnt <= '0;
      end else if (cnt == CW'(DEB_CYCLES - 1)) begin
        deb <= sync2;
        cnt <= '0;
      end else begin
        cnt <= cnt + CW'(1);
      end
      press <= armed & deb_d & ~deb;
    end
  end
endmodule

module cpu_clock_ctrl #(
  parameter int DEB_CYCLES = 500000,
  parameter int PRE_W      = 32
) (
  input  logic        clkin,
  input  logic        reset_n,
  input  logic        key_step_n,
  input  logic        key_mode_n,
  input  logic [4:0]  divisor,
  input  logic        brk,
  output logic        tick_en,
  output logic        run_mode,
  output logic [31:0] tick_cnt
);
  typedef enum logic {ST_STEP = 1'b0, ST_RUN = 1'b1} state_t;

  localparam int DW = (PRE_W > 1) ? $clog2(PRE_W) : 1;

  state_t           state;
  logic             step_press, mode_press, exit_run, pre_rise;
  logic [DW-1:0]    eff_div;
  logic [PRE_W-1:0] pre, pre_nxt;

  cpu_clock_ctrl_btn #(.DEB_CYCLES(DEB_CYCLES)) u_step (
    .clkin   (clkin),
    .reset_n (reset_n),
    .key_n   (key_step_n),
    .press   (step_press)
  );

  cpu_clock_ctrl_btn #(.DEB_CYCLES(DEB_CYCLES)) u_mode (
    .clkin   (clkin),
    .reset_n (reset_n),
    .key_n   (key_mode_n),
    .press   (mode_press)
  );

`ifdef CLKCTRL_BREAK_EN
  assign exit_run = mode_press | brk;
`else
  logic unused_brk;
  assign unused_brk = brk;
  assign exit_run   = mode_press;
`endif

  always_comb begin
    if (int'(divisor) >= PRE_W)
      eff_div = DW'(PRE_W - 1);
    else
      eff_div = DW'(divisor);
  end

  // Tick on the 0->1 edge of the selected prescaler bit as it is about to be written.
  assign pre_nxt  = pre + PRE_W'(1);
  assign pre_rise = ~pre[eff_div] & pre_nxt[eff_div];
  assign run_mode = (state == ST_RUN);

  always_ff @(posedge clkin or negedge reset_n) begin
    if (!reset_n) begin
      state   <= ST_STEP;
      tick_en <= 1'b0;
      pre     <= '0;
    end else begin
      case (state)
        ST_STEP: begin
          pre <= '0;
          if (mode_press) begin
            state   <= ST_RUN;
            tick_en <= 1'b0;
          end else begin
            tick_en <= step_press;
          end
        end
        ST_RUN: begin
          if (exit_run) begin
            state   <= ST_STEP;
            tick_en <= 1'b0;
            pre     <= '0;
          end else begin
            pre     <= pre_nxt;
            tick_en <= pre_rise;
          end
        end
      endcase
    end
  end

  always_ff @(posedge clkin or negedge reset_n) begin
    if (!reset_n)
      tick_cnt <= '0;
    else if (tick_en)
      tick_cnt <= tick_cnt + 32'd1;
  end
endmodule

// File: tb/tb_cpu_clock_ctrl.sv
// Directed bench for cpu_clock_ctrl with DEB_CYCLES=4: vector table for bounce/step, hand sequences for RUN, reset and break.
`timescale 1ns/1ps
module tb_cpu_clock_ctrl;
  logic        clkin      = 1'b0;
  logic        reset_n    = 1'b0;
  logic        key_step_n = 1'b1;
  logic        key_mode_n = 1'b1;
  logic        brk        = 1'b0;
  logic [4:0]  divisor    = 5'd3;
  logic        tick_en, run_mode;
  logic [31:0] tick_cnt;

  int   n_vec = 0;
  int   n_bad = 0;
  int   ticks;
  logic e_tick, e_run;

  typedef struct {
    logic        step_n;
    logic        mode_n;
    logic        exp_tick;
    logic        exp_run;
    logic [31:0] exp_cnt;
  } vec_t;

  vec_t vecs[65];

  cpu_clock_ctrl #(.DEB_CYCLES(4), .PRE_W(32)) dut (
    .clkin      (clkin),
    .reset_n    (reset_n),
    .key_step_n (key_step_n),
    .key_mode_n (key_mode_n),
    .divisor    (divisor),
    .brk        (brk),
    .tick_en    (tick_en),
    .run_mode   (run_mode),
    .tick_cnt   (tick_cnt)
  );

  always #5 clkin = ~clkin;

  task automatic cyc();
    @(posedge clkin);
    #1;
  endtask

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  initial begin
    // Rows 0-32: five 2-cycle bounces then idle; rows 33-52: step held; rows 53-64: released.
    for (int i = 0; i < 65; i++) begin
      vecs[i].mode_n   = 1'b1;
      vecs[i].exp_run  = 1'b0;
      if (i < 25)      vecs[i].step_n = ((i % 5) < 2) ? 1'b0 : 1'b1;
      else if (i < 33) vecs[i].step_n = 1'b1;
      else if (i < 53) vecs[i].step_n = 1'b0;
      else             vecs[i].step_n = 1'b1;
      vecs[i].exp_tick = (i == 40);
      vecs[i].exp_cnt  = (i > 40) ? 32'd1 : 32'd0;
    end

    #2;
    check("reset outputs", {tick_en, run_mode, tick_cnt}, 64'd0);
    #21 reset_n = 1'b1;
    repeat (4) cyc();

    for (int i = 0; i < 65; i++) begin
      key_step_n = vecs[i].step_n;
      key_mode_n = vecs[i].mode_n;
      cyc();
      check($sformatf("vec%0d", i), {tick_en, run_mode, tick_cnt},
            {vecs[i].exp_tick, vecs[i].exp_run, vecs[i].exp_cnt});
    end

    // RUN at divisor=3, step presses ignored, ten ticks on the 16-cycle grid.
    divisor    = 5'd3;
    key_mode_n = 1'b0;
    for (int c = 0; c < 163; c++) begin
      if (c == 10)  key_mode_n = 1'b1;
      if (c == 40)  key_step_n = 1'b0;
      if (c == 60)  key_step_n = 1'b1;
      if (c == 100) key_step_n = 1'b0;
      if (c == 115) key_step_n = 1'b1;
      cyc();
      e_run  = (c >= 7);
      e_tick = (c >= 15) && (((c - 15) % 16) == 0);
      check($sformatf("run c%0d", c), {tick_en, run_mode}, {e_tick, e_run});
    end
    check("run tick_cnt", tick_cnt, 64'd11);

    // Asynchronous reset mid-run, with STEP held low through reset.
    #3 reset_n = 1'b0;
    #1;
    check("async rst tick/run", {tick_en, run_mode}, 64'd0);
    check("async rst cnt", tick_cnt, 64'd0);
    key_step_n = 1'b0;
    repeat (2) cyc();
    #2 reset_n = 1'b1;
    repeat (20) cyc();
    check("held through reset cnt", tick_cnt, 64'd0);
    key_step_n = 1'b1;
    repeat (10) cyc();
    key_step_n = 1'b0;
    repeat (10) cyc();
    key_step_n = 1'b1;
    repeat (5) cyc();
    check("repress after reset cnt", tick_cnt, 64'd1);

    // Mode and step presses debounced in the same cycle while in RUN.
    key_mode_n = 1'b0;
    for (int c = 0; c < 30; c++) begin
      if (c == 10) key_mode_n = 1'b1;
      cyc();
    end
    check("enter run", run_mode, 64'd1);
    key_mode_n = 1'b0;
    key_step_n = 1'b0;
    ticks = 0;
    for (int c = 0; c < 31; c++) begin
      if (c == 10) begin
        key_mode_n = 1'b1;
        key_step_n = 1'b0;
      end
      if (c == 12) key_step_n = 1'b1;
      cyc();
      if (c == 6) check("dual press c6 run", run_mode, 64'd1);
      if (c == 7) check("dual press c7", {tick_en, run_mode}, 64'd0);
      if (c >= 7 && tick_en) ticks++;
    end
    check("dual press ticks after", ticks, 64'd0);
    check("dual press final run", run_mode, 64'd0);

    // Break request at divisor=0.
    divisor    = 5'd0;
    key_mode_n = 1'b0;
    for (int c = 0; c < 24; c++) begin
      if (c == 10) key_mode_n = 1'b1;
      cyc();
      if (c >= 20)
        check($sformatf("div0 c%0d", c), {tick_en, run_mode}, {(((c - 8) % 2) == 0), 1'b1});
    end
    brk = 1'b1;
    for (int c = 24; c < 36; c++) begin
      cyc();
`ifdef CLKCTRL_BREAK_EN
      check($sformatf("brk c%0d", c), {tick_en, run_mode}, 64'd0);
`else
      check($sformatf("brk c%0d", c), {tick_en, run_mode}, {(((c - 8) % 2) == 0), 1'b1});
`endif
    end
`ifdef CLKCTRL_BREAK_EN
    key_mode_n = 1'b0;
    for (int c = 0; c < 13; c++) begin
      if (c == 10) key_mode_n = 1'b1;
      cyc();
      if (c == 7) check("brk reenter c7", {tick_en, run_mode}, 64'd1);
      if (c == 8) check("brk reexit c8", {tick_en, run_mode}, 64'd0);
    end
`endif
    brk = 1'b0;
    repeat (2) cyc();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
